// File: rtl/lcb_rx_framer.sv
// Receive framer for one LCB UART channel: turns the byte strobe stream into
// packet RAM writes, detects complete and short packets and tracks overruns.
module lcb_rx_framer #(
    parameter int BYTES   = 24,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              strob,
    input  logic [7:0]        iData,
    input  logic              ack,
    output logic [ADDR_W-1:0] wrAdr,
    output logic [7:0]        wrData,
    output logic              WE,
    output logic              full,
    output logic [ADDR_W:0]   byteCnt,
    output logic              errShort,
    output logic              overrun
);

    localparam int                  TIMER_W    = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0]     LAST_CNT   = (ADDR_W + 1)'(BYTES);
    localparam logic [ADDR_W:0]     FIRST_CNT  = (ADDR_W + 1)'(1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} stateType;

    stateType            state, stateNext;
    logic [TIMER_W-1:0]  timer, timerNext, timerInc;
    logic [ADDR_W-1:0]   wrAdrNext;
    logic [7:0]          wrDataNext;
    logic [ADDR_W:0]     byteCntNext, cntInc;
    logic                weNext, fullNext, errShortNext, overrunNext;

    always_comb begin
        stateNext    = state;
        wrAdrNext    = wrAdr;
        wrDataNext   = wrData;
        weNext       = 1'b0;
        fullNext     = 1'b0;
        byteCntNext  = byteCnt;
        errShortNext = 1'b0;
        overrunNext  = overrun;
        timerNext    = '0;
        cntInc       = byteCnt + 1'b1;
        timerInc     = (timer == '1) ? timer : timer + 1'b1;

        if (start) begin
            stateNext   = IDLE;
            overrunNext = 1'b0;
            byteCntNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strob) begin
                        wrAdrNext   = '0;
                        wrDataNext  = iData;
                        weNext      = 1'b1;
                        byteCntNext = FIRST_CNT;
                        stateNext   = (BYTES == 1) ? DONE : RECV;
                    end
                end
                RECV: begin
                    // A byte on the last allowed cycle wins over the timeout.
                    if (strob) begin
                        wrAdrNext   = byteCnt[ADDR_W-1:0];
                        wrDataNext  = iData;
                        weNext      = 1'b1;
                        byteCntNext = cntInc;
                        if (cntInc == LAST_CNT) begin
                            stateNext = DONE;
                        end
                    end else if (timerInc == TIMER_LAST) begin
                        errShortNext = 1'b1;
                        stateNext    = IDLE;
                    end else begin
                        timerNext = timerInc;
                    end
                end
                DONE: begin
                    // full lags entry into DONE by one cycle so the last RAM write lands first.
                    fullNext = !ack;
                    if (strob) begin
                        overrunNext = 1'b1;
                    end
                    if (ack) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            wrAdr    <= '0;
            wrData   <= '0;
            WE       <= 1'b0;
            full     <= 1'b0;
            byteCnt  <= '0;
            errShort <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= stateNext;
            timer    <= timerNext;
            wrAdr    <= wrAdrNext;
            wrData   <= wrDataNext;
            WE       <= weNext;
            full     <= fullNext;
            byteCnt  <= byteCntNext;
            errShort <= errShortNext;
            overrun  <= overrunNext;
        end
    end

endmodule
